output_column_fifo: RTL

- Per-column output buffer sitting directly upstream of the output fill stage (one instance per systolic-array column).
- Captures finished partial-sum/result words shifted out of a PE column and holds them until the fill stage writes them to the output feature-map memory.
- Presents first-word-fall-through data plus the is_empty status that the fill stage consumes, and takes a pop from the fill stage's write_enable.

---
 rtl/output_column_fifo.sv | 92 +++++++++
 1 files changed

// File: rtl/output_column_fifo.sv
// Per-column result buffer feeding the output fill stage: first-word-fall-through
// FIFO with registered occupancy count and sticky overflow/underflow flags.
module output_column_fifo #(
    parameter int unsigned data_size  = 16,
    parameter int unsigned depth      = 16,
    parameter int unsigned addr_width = 4
) (
    input  logic                  w_clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  logic [data_size-1:0]  din,
    input  logic                  pop,
    output logic [data_size-1:0]  dout,
    output logic                  is_empty,
    output logic                  full,
    output logic [addr_width:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned CNT_W = addr_width + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(depth);

    logic [data_size-1:0]  mem_q [depth];
    logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  pop_ok, push_ok, wr_en;

    // A pop frees a slot in the same cycle, so a full FIFO may still accept a push.
    always_comb begin
        pop_ok  = pop && (count_q != '0);
        push_ok = push && ((count_q != DEPTH_CNT) || pop_ok);
        wr_en   = push_ok && !clear && reset;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + addr_width'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + addr_width'(1);
            if (push_ok && !pop_ok) count_d = count_q + CNT_W'(1);
            if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
            if (push && !push_ok) overflow_d  = 1'b1;
            if (pop && !pop_ok)   underflow_d = 1'b1;
        end
    end

    always_ff @(posedge w_clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left unreset; the count gates what is visible.
    always_ff @(posedge w_clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din;
    end

    always_comb begin
        dout      = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
        is_empty  = (count_q == '0);
        full      = (count_q == DEPTH_CNT);
        count     = count_q;
        overflow  = overflow_q;
        underflow = underflow_q;
    end

endmodule
